ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter n, default 32, data word width in bits.
REQ-002 Parameter AW, default 17, word address width in bits.
REQ-003 Parameter MAXCONS, default 4, maximum consecutive data-port grants while fetch waits; legal range 1..15.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 f_req  input  1  fetch read request; held with f_addr stable until f_gnt.
REQ-007 f_addr  input  AW  fetch word address.
REQ-008 f_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-009 f_rvalid  output  1  f_rdata valid (registered).
REQ-010 f_rdata  output  n  fetch read data.
REQ-011 d_req  input  1  load/store request; held with d_we/d_addr/d_wdata stable until d_gnt.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_addr  input  AW  data word address.
REQ-014 d_wdata  input  n  store data.
REQ-015 d_gnt  output  1  data request accepted this cycle (combinational).
REQ-016 d_rvalid  output  1  d_rdata valid (registered); never asserted for stores.
REQ-017 d_rdata  output  n  load read data.
REQ-018 ramR, ramW  output  1 each  RAM read/write strobes.
REQ-019 ram_addr  output  AW; ram_dataW  output  n  RAM address and write data.
REQ-020 ram_dataR  input  n  RAM registered read data, valid the cycle after ramR is sampled.

Function
REQ-021 At most one of f_gnt, d_gnt SHALL be high in any cycle; a grant SHALL be asserted only when the corresponding req is high.
REQ-022 Default priority: d_req high and starve counter < MAXCONS -> grant data; otherwise grant fetch if f_req high.
REQ-023 Starve counter (4 bits): increment on a cycle with d_gnt=1 and f_req=1; clear on any f_gnt=1 or f_req=0; saturate at MAXCONS.
REQ-024 When the counter equals MAXCONS and f_req=1, f_gnt SHALL assert that cycle even if d_req=1; d_req waits.
REQ-025 Data grant: ram_addr=d_addr, ramW=d_we, ramR=~d_we, ram_dataW=d_wdata, all combinational in the grant cycle.
REQ-026 Fetch grant: ram_addr=f_addr, ramR=1, ramW=0.
REQ-027 No grant: ramR=0, ramW=0, ram_addr and ram_dataW = 0.
REQ-028 Read latency: rvalid of the granted read port SHALL be 1 exactly one cycle after the grant, for one cycle per grant.
REQ-029 A registered owner flag SHALL steer ram_dataR to f_rdata or d_rdata; the non-owner rdata output and both rdata outputs when no rvalid SHALL be 0.
REQ-030 Back-to-back grants SHALL be supported every cycle with no bubbles: full throughput of one access per cycle.
REQ-031 A load and a fetch to the same address in consecutive cycles SHALL both return the RAM contents; a store followed by a load to the same address SHALL return the stored value.
REQ-032 Requests deasserted before grant are a protocol violation; behaviour is undefined but grants SHALL still be mutually exclusive.

Reset
REQ-033 While reset is high: f_rvalid, d_rvalid, f_rdata, d_rdata, starve counter and owner flag SHALL be 0 immediately (asynchronous).
REQ-034 During reset f_gnt, d_gnt, ramR and ramW SHALL be forced 0 regardless of requests.
REQ-035 Reset during a pending read SHALL drop the response: no rvalid SHALL appear after reset deasserts.
REQ-036 First grant is possible in the first cycle after reset deasserts.

Verification
REQ-037 Fetch-only: f_req=1, f_addr=0x00010, mem[0x10]=0xDEADBEEF -> f_gnt same cycle, f_rvalid=1 and f_rdata=0xDEADBEEF next cycle.
REQ-038 Contention: f_req=1 and d_req=1 (load) together -> d_gnt first, then f_gnt next cycle, each rvalid one cycle after its grant, correct data to each port.
REQ-039 Starvation: f_req=1 and d_req=1 held for 10 cycles with MAXCONS=4 -> pattern d,d,d,d,f,d,d,d,d,f; never two grants in one cycle.
REQ-040 Store then load: store 0x12345678 to 0x1FFFF, load 0x1FFFF next cycle -> d_rvalid=1 with d_rdata=0x12345678; no d_rvalid for the store.
REQ-041 Reset mid-read: fetch granted, reset asserted before next edge -> f_rvalid stays 0, all outputs 0; after release fetch works normally.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one synchronous RAM between fetch and data ports.
// Data wins by default; a starve counter bounds how long fetch can wait.
module ram_arbiter #(
   parameter int n       = 32,
   parameter int AW      = 17,
   parameter int MAXCONS = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [n-1:0]  f_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [n-1:0]  d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [n-1:0]  d_rdata,
   output logic          ramR,
   output logic          ramW,
   output logic [AW-1:0] ram_addr,
   output logic [n-1:0]  ram_dataW,
   input  logic [n-1:0]  ram_dataR
);

   localparam logic [3:0] MAXC = 4'(MAXCONS);

   logic [3:0] starve;
   logic       owner;
   logic       d_sel;

   always_comb begin
      d_sel = d_req && (starve < MAXC);
      d_gnt = !reset && d_sel;
      f_gnt = !reset && !d_sel && f_req;
   end

   always_comb begin
      ramR      = 1'b0;
      ramW      = 1'b0;
      ram_addr  = '0;
      ram_dataW = '0;
      if (d_gnt) begin
         ram_addr  = d_addr;
         ramW      = d_we;
         ramR      = !d_we;
         ram_dataW = d_wdata;
      end else if (f_gnt) begin
         ram_addr = f_addr;
         ramR     = 1'b1;
      end
   end

   // owner remembers which port issued last cycle's access
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve   <= '0;
         owner    <= 1'b0;
         f_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
      end else begin
         f_rvalid <= f_gnt;
         d_rvalid <= d_gnt && !d_we;
         owner    <= d_gnt;
         if (f_gnt || !f_req)
            starve <= '0;
         else if (d_gnt && (starve < MAXC))
            starve <= starve + 4'd1;
      end
   end

   always_comb begin
      f_rdata = (f_rvalid && !owner) ? ram_dataR : '0;
      d_rdata = (d_rvalid && owner)  ? ram_dataR : '0;
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic
// checked against a spec-level model with its own memory image.
module tb_ram_arbiter;
   localparam int N    = 32;
   localparam int AW   = 17;
   localparam int MAXC = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          f_req = 1'b0;
   logic [AW-1:0] f_addr = '0;
   logic          f_gnt;
   logic          f_rvalid;
   logic [N-1:0]  f_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [N-1:0]  d_wdata = '0;
   logic          d_gnt;
   logic          d_rvalid;
   logic [N-1:0]  d_rdata;
   logic          ramR;
   logic          ramW;
   logic [AW-1:0] ram_addr;
   logic [N-1:0]  ram_dataW;
   logic [N-1:0]  ram_dataR = '0;

   logic [N-1:0] mem  [0:(1<<AW)-1] = '{default: '0};
   logic [N-1:0] refm [0:(1<<AW)-1] = '{default: '0};

   int checks = 0;
   int errors = 0;

   int           streak = 0;
   bit           pf_v = 0, pd_v = 0;
   logic [N-1:0] pf_d = '0, pd_d = '0;

   ram_arbiter #(.n(N), .AW(AW), .MAXCONS(MAXC)) dut (
      .clock(clock), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
      .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ramR(ramR), .ramW(ramW), .ram_addr(ram_addr),
      .ram_dataW(ram_dataW), .ram_dataR(ram_dataR)
   );

   always #5 clock = ~clock;

   // synchronous RAM: registered read data, write on strobe
   always @(posedge clock) begin
      if (ramR) ram_dataR <= mem[ram_addr];
      if (ramW) mem[ram_addr] <= ram_dataW;
   end

   initial begin
      #1000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      streak = 0;
      pf_v = 0;
      pd_v = 0;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return {AW{1'b1}};
      return AW'($urandom_range(0, 15));
   endfunction

   task automatic step(input bit fr, input logic [AW-1:0] fa,
                       input bit dr, input bit dwe,
                       input logic [AW-1:0] da,
                       input logic [N-1:0] dwd,
                       output bit fg, output bit dg);
      bit ed, ef;
      @(negedge clock);
      f_req = fr; f_addr = fa;
      d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
      #1;
      ed = dr && (streak < MAXC);
      ef = !ed && fr;
      chk("d_gnt", d_gnt, ed);
      chk("f_gnt", f_gnt, ef);
      chk("excl", f_gnt && d_gnt, 0);
      chk("ramR", ramR, ef || (ed && !dwe));
      chk("ramW", ramW, ed && dwe);
      chk("ram_addr", ram_addr, ed ? da : (ef ? fa : '0));
      if (ed || !ef) chk("ram_dataW", ram_dataW, ed ? dwd : '0);
      chk("f_rvalid", f_rvalid, pf_v);
      chk("f_rdata", f_rdata, pf_v ? pf_d : '0);
      chk("d_rvalid", d_rvalid, pd_v);
      chk("d_rdata", d_rdata, pd_v ? pd_d : '0);
      pf_v = ef;
      pf_d = refm[fa];
      pd_v = ed && !dwe;
      pd_d = refm[da];
      if (ed && dwe) refm[da] = dwd;
      if (ef || !fr) streak = 0;
      else if (ed && streak < MAXC) streak++;
      fg = f_gnt;
      dg = d_gnt;
   endtask

   initial begin
      bit fg, dg;
      string pat;
      bit fon, don, dwe_r;
      logic [AW-1:0] fa_r, da_r;
      logic [N-1:0] dwd_r;

      f_req = 1'b1;
      d_req = 1'b1;
      #1;
      chk("rst_f_gnt", f_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_ramR", ramR, 0);
      chk("rst_ramW", ramW, 0);
      chk("rst_f_rvalid", f_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_f_rdata", f_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      f_req = 1'b0;
      d_req = 1'b0;
      model_reset();

      // store is granted in the first cycle out of reset
      step(0, '0, 1, 1, 17'h00010, 32'hDEADBEEF, fg, dg);
      chk("first_grant", dg, 1);
      step(1, 17'h00010, 0, 0, '0, '0, fg, dg);
      chk("fetch_gnt", fg, 1);
      step(0, '0, 0, 0, '0, '0, fg, dg);
      chk("fetch_rvalid", f_rvalid, 1);
      chk("fetch_data", f_rdata, 32'hDEADBEEF);

      // contention: data first, fetch next
      step(0, '0, 1, 1, 17'h00020, 32'hA5A5A5A5, fg, dg);
      step(0, '0, 1, 1, 17'h00030, 32'h0BADF00D, fg, dg);
      step(1, 17'h00030, 1, 0, 17'h00020, '0, fg, dg);
      chk("cont_d_first", dg, 1);
      step(1, 17'h00030, 0, 0, '0, '0, fg, dg);
      chk("cont_f_next", fg, 1);
      chk("cont_d_data", d_rdata, 32'hA5A5A5A5);
      step(0, '0, 0, 0, '0, '0, fg, dg);
      chk("cont_f_data", f_rdata, 32'h0BADF00D);

      // starvation bound
      pat = "";
      for (int i = 0; i < 10; i++) begin
         step(1, 17'h00020, 1, 0, 17'h00030, '0, fg, dg);
         pat = {pat, dg ? "d" : (fg ? "f" : "-")};
      end
      checks++;
      assert (pat == "ddddfddddf") else begin
         errors++;
         $error("FAIL starve_pattern observed=%s expected=ddddfddddf", pat);
      end
      step(0, '0, 0, 0, '0, '0, fg, dg);

      // store then load at the top address
      step(0, '0, 1, 1, 17'h1FFFF, 32'h12345678, fg, dg);
      step(0, '0, 1, 0, 17'h1FFFF, '0, fg, dg);
      chk("store_no_rvalid", d_rvalid, 0);
      step(0, '0, 0, 0, '0, '0, fg, dg);
      chk("load_rvalid", d_rvalid, 1);
      chk("load_data", d_rdata, 32'h12345678);

      // load then fetch to the same address
      step(0, '0, 1, 0, 17'h1FFFF, '0, fg, dg);
      step(1, 17'h1FFFF, 0, 0, '0, '0, fg, dg);
      step(0, '0, 0, 0, '0, '0, fg, dg);
      chk("same_addr_fetch", f_rdata, 32'h12345678);

      // reset while a fetch read is in flight
      @(negedge clock);
      f_req = 1'b1; f_addr = 17'h00010; d_req = 1'b0;
      #1;
      chk("mid_f_gnt", f_gnt, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_f_gnt", f_gnt, 0);
      chk("mid_rst_ramR", ramR, 0);
      chk("mid_rst_addr", ram_addr, 0);
      @(posedge clock);
      #1;
      chk("mid_rst_f_rvalid", f_rvalid, 0);
      chk("mid_rst_f_rdata", f_rdata, 0);
      chk("mid_rst_d_rvalid", d_rvalid, 0);
      @(negedge clock);
      reset = 1'b0;
      f_req = 1'b0;
      model_reset();
      step(0, '0, 0, 0, '0, '0, fg, dg);
      step(1, 17'h00010, 0, 0, '0, '0, fg, dg);
      step(0, '0, 0, 0, '0, '0, fg, dg);
      chk("post_rst_fetch", f_rdata, 32'hDEADBEEF);

      // random traffic, requests held until granted
      fon = 0; don = 0; dwe_r = 0;
      fa_r = '0; da_r = '0; dwd_r = '0;
      for (int i = 0; i < 400; i++) begin
         if (!fon && $urandom_range(0, 2) != 0) begin
            fon = 1;
            fa_r = rnd_addr();
         end
         if (!don && $urandom_range(0, 2) != 0) begin
            don = 1;
            dwe_r = 1'($urandom_range(0, 1));
            da_r = rnd_addr();
            dwd_r = $urandom;
         end
         step(fon, fa_r, don, dwe_r, da_r, dwd_r, fg, dg);
         if (fg) fon = 0;
         if (dg) don = 0;
      end
      step(0, '0, 0, 0, '0, '0, fg, dg);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
